// File: rtl/timer_sched.sv
// Shares a pool of three one-shot timers among NREQ requesters. Arm and disable
// writes go out on a simple register bus; expiries are reported per requester.
module timer_sched #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned NTMR = 3,
  localparam int unsigned CMPW = 16,
  localparam int unsigned SELW = 2,
  localparam int unsigned TW   = 2,
  localparam int unsigned DW   = 32,
  localparam int unsigned BEW  = 4
) (
  input  logic                   mclk,
  input  logic                   h_reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [CMPW*NREQ-1:0]   req_compare,
  input  logic [SELW*NREQ-1:0]   req_clksel,
  output logic [NREQ-1:0]        req_busy,
  output logic [NREQ-1:0]        req_done,
  output logic                   reg_cs,
  output logic                   reg_wr,
  output logic [TW-1:0]          reg_addr,
  output logic [DW-1:0]          reg_wdata,
  output logic [BEW-1:0]         reg_be,
  input  logic [DW-1:0]          reg_rdata,
  input  logic                   reg_ack,
  input  logic [NTMR-1:0]        timer_intr
);

  localparam int unsigned RW   = $clog2(NREQ);
  localparam int unsigned PADW = DW - CMPW - SELW - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    DIS  = 2'd2
  } state_t;

  state_t                  state, state_d;
  logic                    start_hold;
  logic                    cs_d, wr_d;
  logic [TW-1:0]           addr_d;
  logic [DW-1:0]           wdata_d;
  logic [NREQ-1:0]         busy_d, done_d;
  logic [NTMR-1:0]         used, used_d;
  logic [NTMR-1:0]         flag, flag_d;
  logic [NTMR-1:0][RW-1:0] owner, owner_d;
  logic [RW-1:0]           rr, rr_d;
  logic [RW-1:0]           cur_req, cur_req_d;
  logic [TW-1:0]           cur_tmr, cur_tmr_d;

  logic [NREQ-1:0]         elig;
  logic                    grant_ok;
  logic [RW-1:0]           grant_idx;
  logic                    free_ok, exp_ok;
  logic [TW-1:0]           free_idx, exp_idx;

  logic                    unused_rdata;

  assign unused_rdata = ^reg_rdata;
  assign reg_be       = {BEW{1'b1}};
  assign elig         = req & ~req_busy;

  // Round-robin pick: first eligible requester at or after rr (descending loop, lowest offset wins).
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = rr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[RW'(rr + RW'(k))]) begin
        grant_ok  = 1'b1;
        grant_idx = RW'(rr + RW'(k));
      end
    end
  end

  // Lowest-index free timer and lowest-index expired timer.
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    exp_ok   = 1'b0;
    exp_idx  = '0;
    for (int t = NTMR - 1; t >= 0; t--) begin
      if (!used[t]) begin
        free_ok  = 1'b1;
        free_idx = TW'(t);
      end
      if (flag[t]) begin
        exp_ok  = 1'b1;
        exp_idx = TW'(t);
      end
    end
  end

  // Next-state and next-output logic; expiry service outranks arming.
  always_comb begin
    state_d   = state;
    cs_d      = reg_cs;
    wr_d      = reg_wr;
    addr_d    = reg_addr;
    wdata_d   = reg_wdata;
    busy_d    = req_busy;
    done_d    = '0;
    used_d    = used;
    owner_d   = owner;
    rr_d      = rr;
    cur_req_d = cur_req;
    cur_tmr_d = cur_tmr;
    flag_d    = flag | (timer_intr & used);

    unique case (state)
      IDLE: begin
        if (!start_hold) begin
          if (exp_ok) begin
            state_d   = DIS;
            cs_d      = 1'b1;
            wr_d      = 1'b1;
            addr_d    = TW'(exp_idx + 1'b1);
            wdata_d   = '0;
            cur_tmr_d = exp_idx;
            cur_req_d = owner[exp_idx];
          end else if (grant_ok && free_ok) begin
            state_d   = ARM;
            cs_d      = 1'b1;
            wr_d      = 1'b1;
            addr_d    = TW'(free_idx + 1'b1);
            wdata_d   = {{PADW{1'b0}},
                         req_clksel[SELW*grant_idx +: SELW],
                         1'b1,
                         req_compare[CMPW*grant_idx +: CMPW]};
            cur_tmr_d = free_idx;
            cur_req_d = grant_idx;
          end
        end
      end
      ARM: begin
        if (reg_ack) begin
          state_d          = IDLE;
          cs_d             = 1'b0;
          wr_d             = 1'b0;
          owner_d[cur_tmr] = cur_req;
          busy_d[cur_req]  = 1'b1;
          used_d[cur_tmr]  = 1'b1;
          rr_d             = RW'(cur_req + 1'b1);
        end
      end
      DIS: begin
        if (reg_ack) begin
          state_d         = IDLE;
          cs_d            = 1'b0;
          wr_d            = 1'b0;
          done_d[cur_req] = 1'b1;
          busy_d[cur_req] = 1'b0;
          used_d[cur_tmr] = 1'b0;
          // Clearing wins over a coincident interrupt on the timer being disabled.
          flag_d[cur_tmr] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; start_hold blocks bus activity for one cycle after reset release.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state      <= IDLE;
      start_hold <= 1'b1;
      reg_cs     <= 1'b0;
      reg_wr     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      req_busy   <= '0;
      req_done   <= '0;
      used       <= '0;
      flag       <= '0;
      owner      <= '0;
      rr         <= '0;
      cur_req    <= '0;
      cur_tmr    <= '0;
    end else begin
      state      <= state_d;
      start_hold <= 1'b0;
      reg_cs     <= cs_d;
      reg_wr     <= wr_d;
      reg_addr   <= addr_d;
      reg_wdata  <= wdata_d;
      req_busy   <= busy_d;
      req_done   <= done_d;
      used       <= used_d;
      flag       <= flag_d;
      owner      <= owner_d;
      rr         <= rr_d;
      cur_req    <= cur_req_d;
      cur_tmr    <= cur_tmr_d;
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: a bus responder with programmable ack delay logs
// every completed write, and each scenario task checks its own expected values.
module tb_timer_sched;

  logic        mclk;
  logic        h_reset_n;
  logic [3:0]  req;
  logic [63:0] req_compare;
  logic [7:0]  req_clksel;
  logic [3:0]  req_busy;
  logic [3:0]  req_done;
  logic        reg_cs;
  logic        reg_wr;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic [2:0]  timer_intr;

  int vectors     = 0;
  int miscompares = 0;

  int          ack_dly  = 0;
  int          wait_cnt = 0;
  logic [1:0]  log_addr[$];
  logic [31:0] log_data[$];

  int          done_cnt[4];
  int          cs_rises  = 0;
  int          proto_err = 0;
  logic        prev_cs   = 1'b0;
  logic [1:0]  prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  logic [3:0]  prev_done = '0;

  timer_sched #(.NREQ(4)) dut (
    .mclk        (mclk),
    .h_reset_n   (h_reset_n),
    .req         (req),
    .req_compare (req_compare),
    .req_clksel  (req_clksel),
    .req_busy    (req_busy),
    .req_done    (req_done),
    .reg_cs      (reg_cs),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_be      (reg_be),
    .reg_rdata   (reg_rdata),
    .reg_ack     (reg_ack),
    .timer_intr  (timer_intr)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Bus responder: acks after ack_dly waiting cycles and logs the completed write.
  initial begin
    reg_ack   = 1'b0;
    reg_rdata = '0;
    forever begin
      @(posedge mclk);
      #1;
      if (reg_cs && !reg_ack) begin
        if (wait_cnt >= ack_dly) begin
          reg_ack = 1'b1;
          log_addr.push_back(reg_addr);
          log_data.push_back(reg_wdata);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        reg_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Bus-rule and pulse-width monitor.
  always @(negedge mclk) begin
    if (reg_cs && prev_cs && (reg_addr !== prev_addr || reg_wdata !== prev_wdata)) proto_err++;
    if (reg_cs && !prev_cs) cs_rises++;
    if ((req_done & prev_done) != 4'b0) proto_err++;
    if (reg_be !== 4'hF) proto_err++;
    for (int i = 0; i < 4; i++) if (req_done[i]) done_cnt[i]++;
    prev_cs    = reg_cs;
    prev_addr  = reg_addr;
    prev_wdata = reg_wdata;
    prev_done  = req_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] arm_word(input logic [1:0] sel, input logic [15:0] cmp);
    return {13'b0, sel, 1'b1, cmp};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic set_cfg(input int i, input logic [15:0] cmp, input logic [1:0] sel);
    req_compare[16*i +: 16] = cmp;
    req_clksel[2*i +: 2]    = sel;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    int c = 0;
    while (log_addr.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    ok = (log_addr.size() >= n);
  endtask

  task automatic wait_cs(input int budget, output bit ok);
    int c = 0;
    while (!reg_cs && c < budget) begin
      tick(1);
      c++;
    end
    ok = reg_cs;
  endtask

  task automatic clear_stats();
    log_addr.delete();
    log_data.delete();
    for (int i = 0; i < 4; i++) done_cnt[i] = 0;
    cs_rises = 0;
  endtask

  task automatic do_reset();
    h_reset_n   = 1'b0;
    req         = '0;
    timer_intr  = '0;
    ack_dly     = 0;
    req_compare = '0;
    req_clksel  = '0;
    tick(2);
    clear_stats();
    h_reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    h_reset_n = 1'b0;
    req = 4'b0001;
    timer_intr = '0;
    set_cfg(0, 16'd5, 2'd0);
    tick(2);
    vectors++;
    if ({reg_cs, reg_wr, reg_addr, reg_wdata, req_busy, req_done} !== 44'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {reg_cs, reg_wr, reg_addr, reg_wdata, req_busy, req_done});
    end
    vectors++;
    if (reg_be !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_be: got %h expected f", reg_be);
    end
    clear_stats();
    h_reset_n = 1'b1;
    tick(1);
    vectors++;
    if (reg_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL release_quiet: got cs=%b expected 0", reg_cs);
    end
    tick(1);
    vectors++;
    if ({reg_cs, reg_wr, reg_addr, reg_wdata} !== {1'b1, 1'b1, 2'd1, 32'h0001_0005}) begin
      miscompares++;
      $display("FAIL release_arm: got %h expected %h", {reg_cs, reg_wr, reg_addr, reg_wdata},
               {1'b1, 1'b1, 2'd1, 32'h0001_0005});
    end
    tick(3);
  endtask

  task automatic test_single_request();
    do_reset();
    set_cfg(0, 16'd5, 2'd0);
    req = 4'b0001;
    tick(1);
    vectors++;
    if ({reg_cs, reg_wr, reg_addr, reg_wdata} !== {1'b1, 1'b1, 2'd1, 32'h0001_0005}) begin
      miscompares++;
      $display("FAIL single_arm: got %h expected %h", {reg_cs, reg_wr, reg_addr, reg_wdata},
               {1'b1, 1'b1, 2'd1, 32'h0001_0005});
    end
    tick(1);
    vectors++;
    if ({reg_cs, req_busy} !== {1'b0, 4'b0001}) begin
      miscompares++;
      $display("FAIL single_busy: got %h expected %h", {reg_cs, req_busy}, {1'b0, 4'b0001});
    end
    req = 4'b0000;
    tick(4);
    vectors++;
    if (cs_rises !== 1 || req_busy !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_drop_req: got rises=%0d busy=%b expected rises=1 busy=0001",
               cs_rises, req_busy);
    end
    timer_intr = 3'b001;
    tick(1);
    timer_intr = 3'b000;
    tick(1);
    vectors++;
    if ({reg_cs, reg_wr, reg_addr, reg_wdata} !== {1'b1, 1'b1, 2'd1, 32'h0}) begin
      miscompares++;
      $display("FAIL single_disable: got %h expected %h", {reg_cs, reg_wr, reg_addr, reg_wdata},
               {1'b1, 1'b1, 2'd1, 32'h0});
    end
    tick(1);
    vectors++;
    if ({reg_cs, req_done, req_busy} !== {1'b0, 4'b0001, 4'b0000}) begin
      miscompares++;
      $display("FAIL single_done: got %h expected %h", {reg_cs, req_done, req_busy},
               {1'b0, 4'b0001, 4'b0000});
    end
    tick(1);
    vectors++;
    if (req_done !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_done_width: got %b expected 0000", req_done);
    end
    tick(3);
    vectors++;
    if (done_cnt[0] !== 1 || cs_rises !== 2) begin
      miscompares++;
      $display("FAIL single_counts: got done=%0d rises=%0d expected done=1 rises=2",
               done_cnt[0], cs_rises);
    end
  endtask

  task automatic test_exhaustion();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) set_cfg(i, 16'(16'h0010 + i), 2'(i));
    req = 4'b1111;
    wait_log(3, 50, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL exh_first3: got %0d writes expected 3", log_addr.size());
    end
    tick(2);
    vectors++;
    if (req_busy !== 4'b0111) begin
      miscompares++;
      $display("FAIL exh_busy: got %b expected 0111", req_busy);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (log_addr[k] !== 2'(k + 1) || log_data[k] !== arm_word(2'(k), 16'(16'h0010 + k))) begin
        miscompares++;
        $display("FAIL exh_grant%0d: got addr=%0d data=%h expected addr=%0d data=%h", k,
                 log_addr[k], log_data[k], k + 1, arm_word(2'(k), 16'(16'h0010 + k)));
      end
    end
    tick(10);
    vectors++;
    if (log_addr.size() !== 3 || reg_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL exh_wait: got writes=%0d cs=%b expected writes=3 cs=0",
               log_addr.size(), reg_cs);
    end
    timer_intr = 3'b010;
    tick(1);
    timer_intr = 3'b000;
    wait_log(5, 50, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL exh_refill: got %0d writes expected 5", log_addr.size());
    end
    tick(2);
    vectors++;
    if (log_addr[3] !== 2'd2 || log_data[3] !== 32'h0) begin
      miscompares++;
      $display("FAIL exh_dis1: got addr=%0d data=%h expected addr=2 data=0",
               log_addr[3], log_data[3]);
    end
    vectors++;
    if (log_addr[4] !== 2'd2 || log_data[4] !== arm_word(2'd3, 16'h0013)) begin
      miscompares++;
      $display("FAIL exh_req3: got addr=%0d data=%h expected addr=2 data=%h",
               log_addr[4], log_data[4], arm_word(2'd3, 16'h0013));
    end
    vectors++;
    if (req_busy !== 4'b1101 || done_cnt[1] !== 1) begin
      miscompares++;
      $display("FAIL exh_final: got busy=%b done1=%0d expected busy=1101 done1=1",
               req_busy, done_cnt[1]);
    end
  endtask

  task automatic test_priority();
    bit ok;
    logic [1:0]  ea[3];
    logic [31:0] ed[3];
    do_reset();
    for (int i = 0; i < 4; i++) set_cfg(i, 16'(16'h0100 + i), 2'(3 - i));
    req = 4'b0111;
    wait_log(3, 50, ok);
    tick(2);
    req = 4'b0110;
    timer_intr = 3'b001;
    tick(1);
    timer_intr = 3'b000;
    wait_log(4, 50, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL prio_setup: got %0d writes expected 4", log_addr.size());
    end
    tick(3);
    ack_dly = 5;
    req = 4'b1110;
    wait_cs(10, ok);
    tick(2);
    vectors++;
    if (!ok || reg_cs !== 1'b1 || log_addr.size() !== 4) begin
      miscompares++;
      $display("FAIL prio_arm_pending: got cs=%b writes=%0d expected cs=1 writes=4",
               reg_cs, log_addr.size());
    end
    req = 4'b1011;
    timer_intr = 3'b100;
    tick(1);
    timer_intr = 3'b000;
    wait_log(7, 80, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL prio_sequence: got %0d writes expected 7", log_addr.size());
    end
    tick(2);
    ea = '{2'd1, 2'd3, 2'd3};
    ed = '{arm_word(2'd0, 16'h0103), 32'h0, arm_word(2'd3, 16'h0100)};
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (log_addr[k + 4] !== ea[k] || log_data[k + 4] !== ed[k]) begin
        miscompares++;
        $display("FAIL prio_write%0d: got addr=%0d data=%h expected addr=%0d data=%h", k + 4,
                 log_addr[k + 4], log_data[k + 4], ea[k], ed[k]);
      end
    end
    vectors++;
    if (req_busy !== 4'b1011 || done_cnt[2] !== 1) begin
      miscompares++;
      $display("FAIL prio_final: got busy=%b done2=%0d expected busy=1011 done2=1",
               req_busy, done_cnt[2]);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [1:0]  ea[8];
    logic [31:0] ed[8];
    logic [31:0] a0, a1;
    do_reset();
    set_cfg(0, 16'h0AAA, 2'd1);
    set_cfg(1, 16'h0BBB, 2'd2);
    a0 = arm_word(2'd1, 16'h0AAA);
    a1 = arm_word(2'd2, 16'h0BBB);
    req = 4'b0011;
    wait_log(2, 50, ok);
    tick(2);
    timer_intr = 3'b001;
    tick(1);
    timer_intr = 3'b000;
    wait_log(4, 50, ok);
    tick(2);
    timer_intr = 3'b011;
    tick(1);
    timer_intr = 3'b000;
    wait_log(8, 80, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL fair_sequence: got %0d writes expected 8", log_addr.size());
    end
    tick(2);
    ea = '{2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2};
    ed = '{a0, a1, 32'h0, a0, 32'h0, 32'h0, a1, a0};
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (log_addr[k] !== ea[k] || log_data[k] !== ed[k]) begin
        miscompares++;
        $display("FAIL fair_write%0d: got addr=%0d data=%h expected addr=%0d data=%h", k,
                 log_addr[k], log_data[k], ea[k], ed[k]);
      end
    end
    vectors++;
    if (req_busy !== 4'b0011 || done_cnt[0] !== 2 || done_cnt[1] !== 1) begin
      miscompares++;
      $display("FAIL fair_final: got busy=%b done0=%0d done1=%0d expected busy=0011 done0=2 done1=1",
               req_busy, done_cnt[0], done_cnt[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    set_cfg(0, 16'h0200, 2'd0);
    set_cfg(1, 16'h0201, 2'd1);
    set_cfg(2, 16'h0222, 2'd3);
    req = 4'b0011;
    wait_log(1, 50, ok);
    tick(1);
    ack_dly = 20;
    wait_cs(10, ok);
    tick(2);
    vectors++;
    if (!ok || reg_cs !== 1'b1 || req_busy !== 4'b0001) begin
      miscompares++;
      $display("FAIL rstmid_pending: got cs=%b busy=%b expected cs=1 busy=0001", reg_cs, req_busy);
    end
    h_reset_n = 1'b0;
    #1;
    vectors++;
    if ({reg_cs, reg_wr, reg_addr, reg_wdata, req_busy, req_done} !== 44'h0) begin
      miscompares++;
      $display("FAIL rstmid_async: got %h expected 0",
               {reg_cs, reg_wr, reg_addr, reg_wdata, req_busy, req_done});
    end
    req = 4'b0100;
    ack_dly = 0;
    tick(2);
    clear_stats();
    h_reset_n = 1'b1;
    wait_log(1, 20, ok);
    tick(2);
    vectors++;
    if (!ok || log_addr[0] !== 2'd1 || log_data[0] !== arm_word(2'd3, 16'h0222)) begin
      miscompares++;
      $display("FAIL rstmid_regrant: got addr=%0d data=%h expected addr=1 data=%h",
               log_addr[0], log_data[0], arm_word(2'd3, 16'h0222));
    end
    vectors++;
    if (req_busy !== 4'b0100) begin
      miscompares++;
      $display("FAIL rstmid_busy: got %b expected 0100", req_busy);
    end
  endtask

  task automatic test_stray_intr();
    bit ok;
    do_reset();
    set_cfg(0, 16'h0033, 2'd2);
    timer_intr = 3'b010;
    tick(1);
    timer_intr = 3'b000;
    tick(10);
    vectors++;
    if (cs_rises !== 0 || log_addr.size() !== 0 || (done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3]) !== 0) begin
      miscompares++;
      $display("FAIL stray_quiet: got rises=%0d writes=%0d expected 0 and 0",
               cs_rises, log_addr.size());
    end
    req = 4'b0001;
    wait_log(1, 20, ok);
    vectors++;
    if (!ok || log_addr[0] !== 2'd1 || log_data[0] !== arm_word(2'd2, 16'h0033)) begin
      miscompares++;
      $display("FAIL stray_no_flag: got addr=%0d data=%h expected addr=1 data=%h",
               log_addr[0], log_data[0], arm_word(2'd2, 16'h0033));
    end
    tick(3);
  endtask

  task automatic test_protocol();
    vectors++;
    if (proto_err !== 0) begin
      miscompares++;
      $display("FAIL bus_rules: got %0d violations expected 0", proto_err);
    end
  endtask

  initial begin
    h_reset_n   = 1'b1;
    req         = '0;
    req_compare = '0;
    req_clksel  = '0;
    timer_intr  = '0;
    #3;
    test_reset();
    test_single_request();
    test_exhaustion();
    test_priority();
    test_fairness();
    test_reset_mid();
    test_stray_intr();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters (fixed at 4 in this release).
REQ-002 mclk  input  1  master clock; all logic on rising edge.
REQ-003 h_reset_n  input  1  asynchronous active-low reset.
REQ-004 req  input  4  per-requester level request for a one-shot timeout.
REQ-005 req_compare  input  64  16-bit compare per requester; requester i uses bits [16i+15:16i].
REQ-006 req_clksel  input  8  2-bit clock select per requester; requester i uses bits [2i+1:2i].
REQ-007 req_busy  output  4  requester i currently owns a timer.
REQ-008 req_done  output  4  one-cycle pulse: the timeout of requester i has expired.
REQ-009 reg_cs, reg_wr  output  1 each  register-bus master strobes toward the timer block.
REQ-010 reg_addr  output  2  register address; timer n is at address n+1 (n = 0..2).
REQ-011 reg_wdata  output  32  write data; reg_be output 4, always 4'hF.
REQ-012 reg_rdata  input  32  unused; reg_ack input 1, write completion.
REQ-013 timer_intr  input  3  per-timer expiry pulse from the timer block.

Function
REQ-014 Three timers form a pool shared among four requesters; each free timer is allocated to at most one requester.
REQ-015 Requester i is eligible when req[i]=1, req_busy[i]=0, and no request is in flight.
REQ-016 Arbitration is round-robin; the search starts at the requester after the last one granted. After reset, search starts at requester 0.
REQ-017 The allocated timer is the lowest-index free timer.
REQ-018 An arm write drives reg_wdata = {13'b0, clksel, 1'b1, compare} to that timer's address.
REQ-019 A disable write drives reg_wdata = 32'h0 to the owning timer's address.
REQ-020 Each timer keeps a sticky expiry flag, set by timer_intr[n]=1 while that timer is owned. The flag is set even while the FSM is busy. A pulse on an unowned timer is ignored.
REQ-021 FSM states:
- IDLE: if any expiry flag is set, go to DIS for the lowest-index flagged timer (expiry has priority over arming). Else, if an eligible requester exists and a timer is free, go to ARM. Else stay in IDLE.
- ARM: reg_cs=1, reg_wr=1 held until reg_ack=1. On ack: record owner, set req_busy, mark the timer used, advance the round-robin pointer, go to IDLE.
- DIS: reg_cs=1, reg_wr=1 held until reg_ack=1. On ack: pulse req_done of the owner for 1 cycle, clear req_busy, free the timer, clear its flag, go to IDLE.
REQ-022 Bus rules:
- reg_addr and reg_wdata are stable while reg_cs=1.
- reg_cs drops in the cycle after reg_ack.
- At least one IDLE cycle separates consecutive transactions.
REQ-023 Request inputs (req_compare, req_clksel) are sampled in the IDLE-to-ARM transition cycle; later changes do not affect the armed timer.
REQ-024 Dropping req[i] while owning a timer does not cancel the timer; req_done[i] still pulses on expiry.
REQ-025 If req[i] is still high after req_done[i], requester i becomes eligible again on the next arbitration (periodic use).
REQ-026 With all three timers owned, a fourth request waits until one is freed by DIS.
REQ-027 If a timer_intr pulse coincides with the DIS ack for the same timer, it is not re-flagged.
REQ-028 Latency: with an idle FSM and an immediate reg_ack, reg_cs rises 1 cycle after req rises, and req_done rises 1 cycle after the disable ack.

Reset
REQ-029 Asynchronous assertion of h_reset_n=0 does all of the following, regardless of any transaction in progress:
- FSM goes to IDLE.
- reg_cs=0, reg_wr=0, reg_addr=0, reg_wdata=0.
- req_busy=0, req_done=0.
- All timers are freed, all expiry flags are cleared, and the round-robin pointer returns to 0.
REQ-030 Deassertion takes effect on the next mclk edge; no bus transaction is issued in the first cycle after release.

Verification
REQ-031 Single request: req=4'b0001, compare=16'd5, clksel=0 -> write addr 1, data 32'h0001_0005. After timer_intr[0]: write addr 1, data 0, then req_done[0] pulses once.
REQ-032 Pool exhaustion: req=4'b1111 together -> grants in order 0,1,2 on timers 0,1,2. Requester 3 waits and is armed on timer 1 right after timer_intr[1] is serviced.
REQ-033 Priority: timer_intr[2] arrives while an ARM write waits for reg_ack (ack delayed 5 cycles) -> the ARM completes, DIS on addr 3 follows, and the pending arm of another requester follows after that.
REQ-034 Fairness: req=4'b0011 held high continuously with repeated expiries -> grants alternate 0,1,0,1; neither requester is granted twice in a row.
REQ-035 Reset mid-transaction: h_reset_n=0 while reg_cs=1 -> reg_cs=0 and req_busy=0 immediately. After release with req=4'b0100: first grant goes to requester 2 on timer 0.
REQ-036 Stray interrupt: timer_intr[1] pulses with timer 1 unowned -> no bus transaction and no req_done.
